ga_engine: RTL and testbench
============================

// Module: ga_engine
// PURPOSE
//  Hardware genetic-algorithm engine with on-chip population RAM, tournament selection, configurable crossover and mutation.
//  Loads a population serially, then evolves it until an iteration target is reached or a perfect chromosome appears.
//  Top of the GA datapath; host-controlled through start/load strobes and static configuration inputs.
//  Fitness is popcount; perfect = all ones.
// PARAMETERS
//  CHROMOSOME_WIDTH  16  bits per chromosome
//  FITNESS_WIDTH     14  fitness word width; popcount is zero-extended into it
//  POPULATION_SIZE   16  entries; power of two, >=4
// PORTS
//  clk  in  1  single clock, rising edge
//  rst  in  1  asynchronous, active-low reset
//  start_ga  in  1  one-cycle pulse; starts population load from IDLE or DONE
//  load_initial_population  in  1  strobe; stores data_in while in INIT
//  data_in  in  CW  chromosome to load
//  crossover_mode  in  2  00 fixed point, 01 uniform, 10 random single point, 11 treated as 00
//  crossover_single_double  in  1  mode 00 only: 0 single point, 1 double point
//  crossover_single_point  in  log2(CW)  child = p1 bits [CW-1:pt], p2 bits [pt-1:0]
//  crossover_double_point1/2  in  log2(CW) each  bits in [min,max) come from p2, all other bits from p1
//  uniform_crossover_mask  in  CW  mask bit 1 takes p2, 0 takes p1
//  uniform_random_enable  in  1  uniform mode uses the LFSR word as mask instead of uniform_crossover_mask
//  mutation_mode  in  3  000 flip 1 random bit; 001 flip 2 bits (lfsr[3:0], lfsr[7:4]); 010 swap adjacent bits i, i+1 mod CW; others none
//  mutation_rate  in  8  mutate when lfsr[15:8] < rate
//  target_iteration  in  32  number of children to generate
//  busy  out  1  high in INIT and RUNNING
//  done  out  1  high in DONE
//  perfect_found  out  1  sticky; best_fitness == CW
//  best_chromosome  out  CW  fittest population member
//  best_fitness  out  FW  popcount of best_chromosome
//  iteration_count  out  32  children generated so far
//  crossovers_to_perfect  out  32  iteration_count value when perfect first found; 0 otherwise
//  data_out  out  CW  last chromosome written to the population
//  number_of_chromosomes  out  log2(PS)  entries loaded, modulo PS (0 when full)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pipeline P_IDLE; LFSR = 16'hACE1; population cleared.
//  Top FSM: S_IDLE -start_ga-> S_INIT; S_INIT -PS loads done-> S_RUNNING; S_RUNNING -stop-> S_DONE; S_DONE -start_ga-> S_INIT.
//  start_ga in S_INIT or S_RUNNING is ignored.
//  INIT:
//   - Entering clears init_counter, iteration_count, perfect_found, crossovers_to_perfect, best_fitness and best_chromosome.
//   - Each cycle with load high writes data_in to entry init_counter, stores its fitness, then init_counter++.
//   - Best is updated only on strictly greater fitness; ties keep the earlier entry.
//   - After entry PS-1 is written, go to RUNNING next cycle.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; steps every clock while in RUNNING.
//  Pipeline, one cycle per state, P_SELECT -> P_CROSSOVER -> P_MUTATION -> P_EVALUATE -> P_UPDATE, then back to P_SELECT:
//   - P_SELECT: two tournaments. Index pairs lfsr[3:0]/[7:4] pick parent1, [11:8]/[15:12] pick parent2, each mod PS. The higher-fitness entry wins; ties go to the first index.
//   - P_CROSSOVER: crossover per mode. Double point with p1==p2 copies p1.
//   - P_MUTATION: mutation per mode and rate; bit indices come from lfsr mod CW.
//   - P_EVALUATE: child fitness = popcount.
//   - P_UPDATE: replace the worst entry (lowest index on tie) if child fitness >= worst.
//     On replacement: set data_out, update best if child is strictly better, then iteration_count++.
//  Stop is tested at P_UPDATE exit:
//   - stop when iteration_count(new) == target_iteration, or perfect when GA_PERFECT_STOP_EN is defined;
//   - done asserts the next cycle.
//  target_iteration==0: RUNNING exits to DONE immediately, with no children generated.
//  Perfect (best_fitness==CW, including during INIT): perfect_found=1; crossovers_to_perfect latched once.
//  Configuration inputs are sampled at use and must be static while busy.
//  Reset mid-operation aborts to IDLE with reset values.
//  Counters are 32-bit and wrap silently.
// CONFIGURATION
//  GA_PERFECT_STOP_EN:
//   - defined: RUNNING ends at the first UPDATE after perfect_found, or when the target is reached.
//   - undefined: runs exactly target_iteration children; perfect_found still reported.
// TESTING
//  Load 0001,090F,0F02,1234,ABCD,5555,AAAA,0ACE,D2AD,B2EF,0000,1111,2222,3333,4444,0601:
//   -> at INIT end best_chromosome=B2EF, best_fitness=11, number_of_chromosomes=0.
//  Same load, target=20, mode 00 single pt 8, mutation 000 rate 5:
//   -> done 1 cycle after 20th UPDATE, iteration_count=20, best_fitness>=11.
//  Load 16x FFFF, GA_PERFECT_STOP_EN defined:
//   -> perfect_found=1 after load, done after 1 iteration, crossovers_to_perfect=0.
//  target=0 -> done the cycle after RUNNING entry, iteration_count=0.
//  Assert rst low mid-RUNNING -> all outputs 0 immediately; start_ga then restarts INIT cleanly.
//  Uniform mask AAAA with parents FFFF/0000 -> child 5555 before mutation (rate 0).

Source files
------------

// File: rtl/ga_engine.sv
// ga_engine: genetic-algorithm engine with population RAM, tournament selection,
// crossover and mutation. Define GA_PERFECT_STOP_EN to end a run on the first perfect chromosome.
//
// state     | meaning
// S_IDLE    | waiting for start_ga
// S_INIT    | serial population load
// S_RUNNING | evolving through the P_* pipeline
// S_DONE    | run finished, results held
module ga_engine #(
  parameter int CHROMOSOME_WIDTH = 16,
  parameter int FITNESS_WIDTH    = 14,
  parameter int POPULATION_SIZE  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_ga,
  input  logic                                load_initial_population,
  input  logic [CHROMOSOME_WIDTH-1:0]         data_in,
  input  logic [1:0]                          crossover_mode,
  input  logic                                crossover_single_double,
  input  logic [$clog2(CHROMOSOME_WIDTH)-1:0] crossover_single_point,
  input  logic [$clog2(CHROMOSOME_WIDTH)-1:0] crossover_double_point1,
  input  logic [$clog2(CHROMOSOME_WIDTH)-1:0] crossover_double_point2,
  input  logic [CHROMOSOME_WIDTH-1:0]         uniform_crossover_mask,
  input  logic                                uniform_random_enable,
  input  logic [2:0]                          mutation_mode,
  input  logic [7:0]                          mutation_rate,
  input  logic [31:0]                         target_iteration,
  output logic                                busy,
  output logic                                done,
  output logic                                perfect_found,
  output logic [CHROMOSOME_WIDTH-1:0]         best_chromosome,
  output logic [FITNESS_WIDTH-1:0]            best_fitness,
  output logic [31:0]                         iteration_count,
  output logic [31:0]                         crossovers_to_perfect,
  output logic [CHROMOSOME_WIDTH-1:0]         data_out,
  output logic [$clog2(POPULATION_SIZE)-1:0]  number_of_chromosomes
);

  localparam int CW  = CHROMOSOME_WIDTH;
  localparam int FW  = FITNESS_WIDTH;
  localparam int PS  = POPULATION_SIZE;
  localparam int CIW = $clog2(CW);
  localparam int PIW = $clog2(PS);

`ifdef GA_PERFECT_STOP_EN
  localparam bit PERFECT_STOP = 1'b1;
`else
  localparam bit PERFECT_STOP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUNNING, S_DONE} top_state_t;
  typedef enum logic [2:0] {P_IDLE, P_SELECT, P_CROSSOVER, P_MUTATION, P_EVALUATE, P_UPDATE} pipe_state_t;

  top_state_t  state_q, state_d;
  pipe_state_t p_q, p_d;

  logic [CW-1:0]  pop [PS];
  logic [FW-1:0]  fit [PS];
  logic [15:0]    lfsr_q;
  logic [PIW-1:0] init_cnt;
  logic [CW-1:0]  p1_q, p2_q, xo_q, mut_q;
  logic [FW-1:0]  child_fit_q;

  function automatic logic [FW-1:0] popcount(input logic [CW-1:0] v);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < CW; i++) n = n + FW'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [CW-1:0] low_mask(input logic [CIW-1:0] pt);
    return (CW'(1) << pt) - CW'(1);
  endfunction

  assign busy                  = (state_q == S_INIT) || (state_q == S_RUNNING);
  assign done                  = (state_q == S_DONE);
  assign number_of_chromosomes = init_cnt;

  // Tournament selection: higher fitness wins, ties keep the first index
  logic [PIW-1:0] t_a, t_b, t_c, t_d, sel1, sel2;
  always_comb begin
    t_a  = PIW'(32'(lfsr_q[3:0]) % PS);
    t_b  = PIW'(32'(lfsr_q[7:4]) % PS);
    t_c  = PIW'(32'(lfsr_q[11:8]) % PS);
    t_d  = PIW'(32'(lfsr_q[15:12]) % PS);
    sel1 = (fit[t_b] > fit[t_a]) ? t_b : t_a;
    sel2 = (fit[t_d] > fit[t_c]) ? t_d : t_c;
  end

  logic [CW-1:0]  xo_mask, xo_child;
  logic [CIW-1:0] dp_lo, dp_hi, rnd_pt;
  always_comb begin
    xo_mask = '0;
    rnd_pt  = CIW'(32'(lfsr_q[3:0]) % CW);
    dp_lo   = (crossover_double_point1 < crossover_double_point2) ? crossover_double_point1
                                                                   : crossover_double_point2;
    dp_hi   = (crossover_double_point1 < crossover_double_point2) ? crossover_double_point2
                                                                   : crossover_double_point1;
    unique case (crossover_mode)
      2'b01:   xo_mask = uniform_random_enable ? CW'(lfsr_q) : uniform_crossover_mask;
      2'b10:   xo_mask = low_mask(rnd_pt);
      default: begin
        if (!crossover_single_double) xo_mask = low_mask(crossover_single_point);
        else                          xo_mask = low_mask(dp_hi) & ~low_mask(dp_lo);
      end
    endcase
    xo_child = (p1_q & ~xo_mask) | (p2_q & xo_mask);
  end

  logic [CW-1:0]  mut_child;
  logic [CIW-1:0] m_a, m_b, m_next;
  always_comb begin
    mut_child = xo_q;
    m_a       = CIW'(32'(lfsr_q[3:0]) % CW);
    m_b       = CIW'(32'(lfsr_q[7:4]) % CW);
    m_next    = (m_a == CIW'(CW - 1)) ? '0 : m_a + CIW'(1);
    if (lfsr_q[15:8] < mutation_rate) begin
      unique case (mutation_mode)
        3'b000: mut_child[m_a] = ~xo_q[m_a];
        3'b001: mut_child = xo_q ^ (CW'(1) << m_a) ^ (CW'(1) << m_b);
        3'b010: begin
          mut_child[m_a]    = xo_q[m_next];
          mut_child[m_next] = xo_q[m_a];
        end
        default: mut_child = xo_q;
      endcase
    end
  end

  logic [PIW-1:0] worst_idx;
  logic [FW-1:0]  worst_fit;
  always_comb begin
    worst_idx = '0;
    worst_fit = fit[0];
    for (int i = 1; i < PS; i++) begin
      if (fit[i] < worst_fit) begin
        worst_fit = fit[i];
        worst_idx = PIW'(i);
      end
    end
  end

  logic          replace, child_better, child_perfect, stop_now, load_better;
  logic [31:0]   iter_next;
  logic [FW-1:0] load_fit;
  always_comb begin
    replace       = (state_q == S_RUNNING) && (p_q == P_UPDATE) && (child_fit_q >= worst_fit);
    child_better  = replace && (child_fit_q > best_fitness);
    child_perfect = child_better && (child_fit_q == FW'(CW));
    iter_next     = iteration_count + 32'(replace);
    stop_now      = (iter_next == target_iteration) ||
                    (PERFECT_STOP && (perfect_found || child_perfect));
    load_fit      = popcount(data_in);
    load_better   = load_fit > best_fitness;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_ga) state_d = S_INIT;
      S_INIT:    if (load_initial_population && init_cnt == PIW'(PS - 1)) state_d = S_RUNNING;
      S_RUNNING: if (target_iteration == '0 || (p_q == P_UPDATE && stop_now)) state_d = S_DONE;
      S_DONE:    if (start_ga) state_d = S_INIT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_d = p_q;
    if (state_q != S_RUNNING) begin
      p_d = (state_d == S_RUNNING) ? P_SELECT : P_IDLE;
    end else if (state_d != S_RUNNING) begin
      p_d = P_IDLE;
    end else begin
      unique case (p_q)
        P_SELECT:    p_d = P_CROSSOVER;
        P_CROSSOVER: p_d = P_MUTATION;
        P_MUTATION:  p_d = P_EVALUATE;
        P_EVALUATE:  p_d = P_UPDATE;
        default:     p_d = P_SELECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      p_q     <= P_IDLE;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PS; i++) begin
        pop[i] <= '0;
        fit[i] <= '0;
      end
      lfsr_q                <= 16'hACE1;
      init_cnt              <= '0;
      p1_q                  <= '0;
      p2_q                  <= '0;
      xo_q                  <= '0;
      mut_q                 <= '0;
      child_fit_q           <= '0;
      perfect_found         <= 1'b0;
      best_chromosome       <= '0;
      best_fitness          <= '0;
      iteration_count       <= '0;
      crossovers_to_perfect <= '0;
      data_out              <= '0;
    end else begin
      if (state_q == S_RUNNING) lfsr_q <= lfsr_step(lfsr_q);

      if ((state_q == S_IDLE || state_q == S_DONE) && start_ga) begin
        init_cnt              <= '0;
        iteration_count       <= '0;
        perfect_found         <= 1'b0;
        crossovers_to_perfect <= '0;
        best_fitness          <= '0;
        best_chromosome       <= '0;
      end

      if (state_q == S_INIT && load_initial_population) begin
        pop[init_cnt] <= data_in;
        fit[init_cnt] <= load_fit;
        data_out      <= data_in;
        init_cnt      <= init_cnt + PIW'(1);
        if (load_better) begin
          best_chromosome <= data_in;
          best_fitness    <= load_fit;
          if (load_fit == FW'(CW) && !perfect_found) begin
            perfect_found         <= 1'b1;
            crossovers_to_perfect <= iteration_count;
          end
        end
      end

      if (state_q == S_RUNNING) begin
        unique case (p_q)
          P_SELECT: begin
            p1_q <= pop[sel1];
            p2_q <= pop[sel2];
          end
          P_CROSSOVER: xo_q <= xo_child;
          P_MUTATION:  mut_q <= mut_child;
          P_EVALUATE:  child_fit_q <= popcount(mut_q);
          P_UPDATE: begin
            if (replace) begin
              pop[worst_idx]  <= mut_q;
              fit[worst_idx]  <= child_fit_q;
              data_out        <= mut_q;
              iteration_count <= iter_next;
              if (child_better) begin
                best_chromosome <= mut_q;
                best_fitness    <= child_fit_q;
                // Latch the child count that produced the first perfect chromosome
                if (child_perfect && !perfect_found) begin
                  perfect_found         <= 1'b1;
                  crossovers_to_perfect <= iter_next;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ga_engine.sv
// tb_ga_engine: randomized self-checking bench for ga_engine against a per-child
// behavioural GA model (selection, crossover, mutation, replacement, stop rule).
module tb_ga_engine;

  localparam int CW = 16;
  localparam int FW = 14;
  localparam int PS = 16;

`ifdef GA_PERFECT_STOP_EN
  localparam bit PSTOP = 1'b1;
`else
  localparam bit PSTOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_ga = 1'b0;
  logic          load_initial_population = 1'b0;
  logic [CW-1:0] data_in = '0;
  logic [1:0]    crossover_mode = '0;
  logic          crossover_single_double = 1'b0;
  logic [3:0]    crossover_single_point = '0;
  logic [3:0]    crossover_double_point1 = '0;
  logic [3:0]    crossover_double_point2 = '0;
  logic [CW-1:0] uniform_crossover_mask = '0;
  logic          uniform_random_enable = 1'b0;
  logic [2:0]    mutation_mode = '0;
  logic [7:0]    mutation_rate = '0;
  logic [31:0]   target_iteration = '0;
  logic          busy, done, perfect_found;
  logic [CW-1:0] best_chromosome, data_out;
  logic [FW-1:0] best_fitness;
  logic [31:0]   iteration_count, crossovers_to_perfect;
  logic [3:0]    number_of_chromosomes;

  always #5 clk = ~clk;

  ga_engine dut (
    .clk(clk), .rst(rst), .start_ga(start_ga),
    .load_initial_population(load_initial_population), .data_in(data_in),
    .crossover_mode(crossover_mode), .crossover_single_double(crossover_single_double),
    .crossover_single_point(crossover_single_point),
    .crossover_double_point1(crossover_double_point1),
    .crossover_double_point2(crossover_double_point2),
    .uniform_crossover_mask(uniform_crossover_mask),
    .uniform_random_enable(uniform_random_enable),
    .mutation_mode(mutation_mode), .mutation_rate(mutation_rate),
    .target_iteration(target_iteration), .busy(busy), .done(done),
    .perfect_found(perfect_found), .best_chromosome(best_chromosome),
    .best_fitness(best_fitness), .iteration_count(iteration_count),
    .crossovers_to_perfect(crossovers_to_perfect), .data_out(data_out),
    .number_of_chromosomes(number_of_chromosomes)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  bit [15:0]   ld [PS];
  bit [15:0]   m_pop [PS];
  bit [15:0]   m_lfsr, m_best, m_dout;
  int          m_bestfit;
  int unsigned m_iter, m_ctp;
  bit          m_perf;

  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_start();
    m_iter = 0; m_ctp = 0; m_perf = 0; m_best = '0; m_bestfit = 0;
  endtask

  task automatic model_load(input int idx, input bit [15:0] v);
    m_pop[idx] = v;
    m_dout     = v;
    if ($countones(v) > m_bestfit) begin
      m_best    = v;
      m_bestfit = $countones(v);
      if (m_bestfit == CW && !m_perf) begin m_perf = 1; m_ctp = m_iter; end
    end
  endtask

  // One full child generation; lfsr draws: r0 select, r1 crossover, r2 mutation
  task automatic model_child(output bit stop);
    bit [15:0] r0, r1, r2, p1, p2, c, mask;
    int a, b, i1, i2, wi, cf, lo, hi, k;
    bit tmp;
    r0 = m_lfsr; r1 = lfsr_next(r0); r2 = lfsr_next(r1);
    m_lfsr = r2;
    repeat (3) m_lfsr = lfsr_next(m_lfsr);
    a = int'(r0[3:0]);  b = int'(r0[7:4]);
    i1 = ($countones(m_pop[b]) > $countones(m_pop[a])) ? b : a;
    a = int'(r0[11:8]); b = int'(r0[15:12]);
    i2 = ($countones(m_pop[b]) > $countones(m_pop[a])) ? b : a;
    p1 = m_pop[i1]; p2 = m_pop[i2];
    lo = (crossover_double_point1 < crossover_double_point2) ? int'(crossover_double_point1) : int'(crossover_double_point2);
    hi = (crossover_double_point1 < crossover_double_point2) ? int'(crossover_double_point2) : int'(crossover_double_point1);
    mask = uniform_random_enable ? r1 : uniform_crossover_mask;
    for (int j = 0; j < CW; j++) begin
      if (crossover_mode == 2'b01)      tmp = mask[j];
      else if (crossover_mode == 2'b10) tmp = (j < int'(r1[3:0]));
      else if (!crossover_single_double) tmp = (j < int'(crossover_single_point));
      else                              tmp = (j >= lo) && (j < hi);
      c[j] = tmp ? p2[j] : p1[j];
    end
    if (r2[15:8] < mutation_rate) begin
      a = int'(r2[3:0]); b = int'(r2[7:4]);
      if (mutation_mode == 3'd0) c[a] = ~c[a];
      else if (mutation_mode == 3'd1) begin c[a] = ~c[a]; c[b] = ~c[b]; end
      else if (mutation_mode == 3'd2) begin
        k = (a + 1) % CW; tmp = c[a]; c[a] = c[k]; c[k] = tmp;
      end
    end
    cf = $countones(c);
    wi = 0;
    for (int j = 1; j < PS; j++) if ($countones(m_pop[j]) < $countones(m_pop[wi])) wi = j;
    if (cf >= $countones(m_pop[wi])) begin
      m_pop[wi] = c;
      m_dout    = c;
      m_iter++;
      if (cf > m_bestfit) begin
        m_best = c; m_bestfit = cf;
        if (cf == CW && !m_perf) begin m_perf = 1; m_ctp = m_iter; end
      end
    end
    stop = (m_iter == target_iteration) || (PSTOP && m_perf);
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
    m_lfsr = 16'hACE1;
  endtask

  task automatic run_ga(input string tag);
    int exp_cyc, n, passes;
    bit stop;
    start_ga = 1'b1; tick(); start_ga = 1'b0;
    chk({tag, ":busy_init"}, 32'(busy), 32'd1);
    model_start();
    for (int i = 0; i < PS; i++) begin
      load_initial_population = 1'b1; data_in = ld[i];
      model_load(i, ld[i]);
      tick();
    end
    load_initial_population = 1'b0;
    chk({tag, ":init_best"}, 32'(best_chromosome), 32'(m_best));
    chk({tag, ":init_bfit"}, 32'(best_fitness), 32'(m_bestfit));
    chk({tag, ":init_num"}, 32'(number_of_chromosomes), 32'd0);
    chk({tag, ":init_perf"}, 32'(perfect_found), 32'(m_perf));
    passes = 0; stop = 0;
    if (target_iteration == 0) begin
      m_lfsr = lfsr_next(m_lfsr);
      exp_cyc = 1;
    end else begin
      while (!stop && passes < 4000) begin model_child(stop); passes++; end
      exp_cyc = 5 * passes;
    end
    n = 0;
    while (!done && n < exp_cyc + 50) begin tick(); n++; end
    chk({tag, ":done_cycles"}, 32'(n), 32'(exp_cyc));
    if (!done) begin
      do_reset();
      return;
    end
    chk({tag, ":iter"}, iteration_count, m_iter);
    chk({tag, ":best"}, 32'(best_chromosome), 32'(m_best));
    chk({tag, ":bfit"}, 32'(best_fitness), 32'(m_bestfit));
    chk({tag, ":dout"}, 32'(data_out), 32'(m_dout));
    chk({tag, ":perf"}, 32'(perfect_found), 32'(m_perf));
    chk({tag, ":ctp"}, crossovers_to_perfect, m_ctp);
    chk({tag, ":busy_done"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":busy"}, 32'(busy), 32'd0);
    chk({tag, ":done"}, 32'(done), 32'd0);
    chk({tag, ":perf"}, 32'(perfect_found), 32'd0);
    chk({tag, ":best"}, 32'(best_chromosome), 32'd0);
    chk({tag, ":bfit"}, 32'(best_fitness), 32'd0);
    chk({tag, ":iter"}, iteration_count, 32'd0);
    chk({tag, ":ctp"}, crossovers_to_perfect, 32'd0);
    chk({tag, ":dout"}, 32'(data_out), 32'd0);
    chk({tag, ":num"}, 32'(number_of_chromosomes), 32'd0);
  endtask

  task automatic rand_cfg();
    crossover_mode          = 2'($urandom_range(0, 3));
    crossover_single_double = 1'($urandom_range(0, 1));
    crossover_single_point  = 4'($urandom_range(0, 15));
    crossover_double_point1 = 4'($urandom_range(0, 15));
    crossover_double_point2 = 4'($urandom_range(0, 15));
    uniform_crossover_mask  = 16'($urandom);
    uniform_random_enable   = 1'($urandom_range(0, 1));
    mutation_mode           = 3'($urandom_range(0, 7));
    mutation_rate           = 8'($urandom_range(0, 255));
    target_iteration        = 32'($urandom_range(1, 25));
  endtask

  initial begin
    bit [15:0] vec [PS];
    vec = '{16'h0001, 16'h090F, 16'h0F02, 16'h1234, 16'hABCD, 16'h5555, 16'hAAAA, 16'h0ACE,
            16'hD2AD, 16'hB2EF, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0601};
    m_lfsr = 16'hACE1;
    #1;
    chk_zero("reset");
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reference load, single-point crossover at bit 8, single-bit mutation
    ld = vec;
    crossover_mode = 2'b00; crossover_single_double = 1'b0; crossover_single_point = 4'd8;
    mutation_mode = 3'b000; mutation_rate = 8'd5; target_iteration = 32'd20;
    run_ga("directed");
    chk("directed:bfit_min", 32'(best_fitness >= 14'd11), 32'd1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < PS; i++) ld[i] = 16'($urandom);
      rand_cfg();
      run_ga($sformatf("rand%0d", r));
    end

    // Uniform mask AAAA over an all-ones / all-zeros population
    for (int i = 0; i < PS; i++) ld[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
    crossover_mode = 2'b01; uniform_random_enable = 1'b0; uniform_crossover_mask = 16'hAAAA;
    mutation_rate = 8'd0; target_iteration = 32'd4;
    run_ga("uniform");

    ld = vec;
    target_iteration = 32'd0;
    run_ga("target0");

    for (int i = 0; i < PS; i++) ld[i] = 16'hFFFF;
    crossover_mode = 2'b00; mutation_rate = 8'd0; target_iteration = 32'd3;
    run_ga("perfect");

    // Abort mid-run with reset, then restart cleanly
    ld = vec;
    mutation_rate = 8'd40; target_iteration = 32'd1000;
    start_ga = 1'b1; tick(); start_ga = 1'b0;
    for (int i = 0; i < PS; i++) begin
      load_initial_population = 1'b1; data_in = ld[i]; tick();
    end
    load_initial_population = 1'b0;
    repeat (37) tick();
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    tick();
    rst = 1'b1;
    m_lfsr = 16'hACE1;
    tick();
    target_iteration = 32'd10;
    run_ga("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
